punc_state_dumper: RTL and testbench

//  Downstream consumer of the PUnC core's debug ports. On a start pulse it walks PC, R0-R7 and a

---
 rtl/punc_dbg_pkg.sv | 23 ++
 rtl/punc_state_dumper.sv | 185 ++++++++++++++++++
 tb/tb_punc_state_dumper.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/punc_dbg_pkg.sv
// Shared debug-link definitions: dumper FSM states, dump phases and stream tags.
// The host-link decoder reuses the TAG_* constants to demultiplex the stream.
package punc_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PH_PC  = 2'd0,
    PH_REG = 2'd1,
    PH_MEM = 2'd2
  } phase_t;

  localparam logic [1:0] TAG_PC  = 2'b00;
  localparam logic [1:0] TAG_REG = 2'b01;
  localparam logic [1:0] TAG_MEM = 2'b10;

  localparam int REG_IDX_W = 3;

endpackage

// File: rtl/punc_state_dumper.sv
// Read-only observer of the PUnC debug ports: on start it streams PC, R0..R(N-1)
// and a memory window as tagged valid/ready words, one word per FETCH/SEND pair.
module punc_state_dumper
  import punc_dbg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WORD_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_W-1:0]    cfg_base,
  input  logic [WORD_W-1:0]    cfg_count,
  output logic                 busy,
  output logic                 done,
  input  logic [WORD_W-1:0]    pc_debug_data,
  output logic [REG_IDX_W-1:0] rf_debug_addr,
  input  logic [WORD_W-1:0]    rf_debug_data,
  output logic [WORD_W-1:0]    mem_debug_addr,
  input  logic [WORD_W-1:0]    mem_debug_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic [1:0]           out_tag,
  output logic                 out_last
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  state_t               state_r, state_s;
  phase_t               phase_r, phase_s;
  logic [REG_IDX_W-1:0] reg_idx_r, reg_idx_s;
  logic [WORD_W-1:0]    mem_addr_r, mem_addr_s;
  logic [WORD_W-1:0]    base_r, base_s;
  logic [WORD_W-1:0]    remaining_r, remaining_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 out_valid_r, out_valid_s;
  logic [WORD_W-1:0]    out_data_r, out_data_s;
  logic [1:0]           out_tag_r, out_tag_s;
  logic                 out_last_r, out_last_s;

  // Next-state and next-output logic; every register holds unless a branch updates it.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    reg_idx_s   = reg_idx_r;
    mem_addr_s  = mem_addr_r;
    base_s      = base_r;
    remaining_s = remaining_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_tag_s   = out_tag_r;
    out_last_s  = out_last_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          base_s      = cfg_base;
          remaining_s = cfg_count;
          phase_s     = PH_PC;
          reg_idx_s   = {REG_IDX_W{1'b0}};
          busy_s      = 1'b1;
          state_s     = FETCH;
        end else begin
          busy_s = 1'b0;
        end
      end
      FETCH: begin
        out_valid_s = 1'b1;
        state_s     = SEND;
        case (phase_r)
          PH_PC: begin
            out_data_s = pc_debug_data;
            out_tag_s  = TAG_PC;
            out_last_s = 1'b0;
          end
          PH_REG: begin
            out_data_s = rf_debug_data;
            out_tag_s  = TAG_REG;
            out_last_s = (reg_idx_r == LAST_IDX) && (remaining_r == {WORD_W{1'b0}});
          end
          PH_MEM: begin
            out_data_s = mem_debug_data;
            out_tag_s  = TAG_MEM;
            out_last_s = (remaining_r == WORD_W'(1));
          end
          default: begin
            out_data_s = {WORD_W{1'b0}};
            out_tag_s  = TAG_PC;
            out_last_s = 1'b0;
          end
        endcase
      end
      SEND: begin
        if (out_valid_r && out_ready) begin
          out_valid_s = 1'b0;
          state_s     = FETCH;
          case (phase_r)
            PH_PC: begin
              phase_s   = PH_REG;
              reg_idx_s = {REG_IDX_W{1'b0}};
            end
            PH_REG: begin
              if (reg_idx_r != LAST_IDX) begin
                reg_idx_s = reg_idx_r + REG_IDX_W'(1);
              end else if (remaining_r == {WORD_W{1'b0}}) begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
              end else begin
                phase_s    = PH_MEM;
                mem_addr_s = base_r;
              end
            end
            PH_MEM: begin
              // Address wraps naturally at the word width; the count is never clipped.
              if (remaining_r > WORD_W'(1)) begin
                mem_addr_s  = mem_addr_r + WORD_W'(1);
                remaining_s = remaining_r - WORD_W'(1);
              end else begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
              end
            end
            default: begin
              state_s = IDLE;
              busy_s  = 1'b0;
            end
          endcase
        end else begin
          out_valid_s = out_valid_r;
        end
      end
      default: begin
        state_s     = IDLE;
        busy_s      = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      phase_r     <= PH_PC;
      reg_idx_r   <= {REG_IDX_W{1'b0}};
      mem_addr_r  <= {WORD_W{1'b0}};
      base_r      <= {WORD_W{1'b0}};
      remaining_r <= {WORD_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      out_tag_r   <= 2'b00;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      reg_idx_r   <= reg_idx_s;
      mem_addr_r  <= mem_addr_s;
      base_r      <= base_s;
      remaining_r <= remaining_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_tag_r   <= out_tag_s;
      out_last_r  <= out_last_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign rf_debug_addr  = reg_idx_r;
  assign mem_debug_addr = mem_addr_r;
  assign out_valid      = out_valid_r;
  assign out_data       = out_data_r;
  assign out_tag        = out_tag_r;
  assign out_last       = out_last_r;

endmodule

// File: tb/tb_punc_state_dumper.sv
// Self-checking bench: a behavioural core model feeds the debug ports and each
// dump is compared against a word list built directly from the dump rules.
module tb_punc_state_dumper;

  logic        clk, rst, start, out_ready;
  logic [15:0] cfg_base, cfg_count;
  logic        busy, done, out_valid, out_last;
  logic [2:0]  rf_debug_addr;
  logic [15:0] pc_debug_data, rf_debug_data, mem_debug_addr, mem_debug_data, out_data;
  logic [1:0]  out_tag;

  logic [15:0] pc_val;
  logic [15:0] regs [8];

  int n_pass = 0;
  int n_total = 0;

  // Words captured by the collector and words predicted by the model.
  logic [15:0] got_data[$], got_addr[$], exp_data[$], exp_addr[$];
  logic [1:0]  got_tag[$], exp_tag[$];
  bit          got_last[$];
  bit          timeout, done_ok, mem_moved;
  int          stall_viol, stall_cnt, busy_err, early_done;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign pc_debug_data  = pc_val;
  assign rf_debug_data  = regs[rf_debug_addr];
  assign mem_debug_data = mem_fn(mem_debug_addr);

  punc_state_dumper #(.NUM_REGS(8), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .busy(busy), .done(done), .pc_debug_data(pc_debug_data), .rf_debug_addr(rf_debug_addr),
    .rf_debug_data(rf_debug_data), .mem_debug_addr(mem_debug_addr),
    .mem_debug_data(mem_debug_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_exp(input logic [15:0] base, input int count);
    exp_data.delete(); exp_tag.delete(); exp_addr.delete();
    exp_data.push_back(pc_val); exp_tag.push_back(2'b00); exp_addr.push_back(16'h0000);
    for (int k = 0; k < 8; k++) begin
      exp_data.push_back(regs[k]); exp_tag.push_back(2'b01); exp_addr.push_back(16'h0000);
    end
    for (int i = 0; i < count; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      exp_data.push_back(mem_fn(a)); exp_tag.push_back(2'b10); exp_addr.push_back(a);
    end
  endtask

  task automatic start_dump(input bit sync);
    if (sync) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Gathers stream words at negedges. mode 0: ready=1, 1: random ready and scrambled cfg,
  // 2: ready held low 5 cycles on word 3. Stops after the post-final-handshake cycle,
  // after abort_words words, or on timeout.
  task automatic collect(input int mode, input int abort_words, input int restart_at);
    int cyc = 0;
    bit fin = 1'b0, last_hs = 1'b0, prev_stall = 1'b0, r;
    logic [15:0] hd; logic [1:0] ht; logic hl;
    got_data.delete(); got_tag.delete(); got_last.delete(); got_addr.delete();
    timeout = 1'b0; done_ok = 1'b0; mem_moved = 1'b0;
    stall_viol = 0; stall_cnt = 0; busy_err = 0; early_done = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        timeout = 1'b1;
        break;
      end
      start = (cyc == restart_at);
      if (mode == 1) begin
        cfg_base = 16'($urandom); cfg_count = 16'($urandom);
      end
      if (mem_debug_addr !== 16'h0000) mem_moved = 1'b1;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== hd || out_tag !== ht || out_last !== hl))
        stall_viol++;
      if (last_hs) begin
        done_ok = (done === 1'b1) && (busy === 1'b0) && (out_valid === 1'b0);
        fin = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_err++;
        if (done !== 1'b0) early_done++;
        case (mode)
          1: r = 1'($urandom_range(0, 1));
          2: r = !(got_data.size() == 3 && out_valid === 1'b1 && stall_cnt < 5);
          default: r = 1'b1;
        endcase
        if (!r && mode == 2) stall_cnt++;
        out_ready = r;
        prev_stall = (out_valid === 1'b1) && !r;
        hd = out_data; ht = out_tag; hl = out_last;
        if (out_valid === 1'b1 && r) begin
          got_data.push_back(out_data); got_tag.push_back(out_tag);
          got_last.push_back(out_last); got_addr.push_back(mem_debug_addr);
          if (out_last === 1'b1) last_hs = 1'b1;
          if (abort_words > 0 && got_data.size() == abort_words) fin = 1'b1;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b1; cfg_base = 16'h1234; cfg_count = 16'h0005; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'h0000 ||
        out_tag !== 2'b00 || rf_debug_addr !== 3'd0 || mem_debug_addr !== 16'h0000)
      $display("FAIL reset_outputs got busy=%b done=%b valid=%b last=%b data=%h tag=%b rf=%0d mem=%h want all 0",
               busy, done, out_valid, out_last, out_data, out_tag, rf_debug_addr, mem_debug_addr);
    else n_pass++;
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_idle got busy=%b valid=%b want 0/0", busy, out_valid);
    else n_pass++;
  endtask

  task automatic test_count_zero;
    pc_val = 16'h4000;
    for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
    cfg_base = 16'h0800; cfg_count = 16'h0000;
    build_exp(16'h0800, 0);
    start_dump(1'b0);
    collect(0, 0, -1);
    n_total++;
    if (timeout || got_data.size() != 9)
      $display("FAIL cnt0_len got %0d timeout=%b want 9", got_data.size(), timeout);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== (i == 8))
        $display("FAIL cnt0_word%0d got %h/%b/%b want %h/%b/%b", i, got_data[i], got_tag[i],
                 got_last[i], exp_data[i], exp_tag[i], (i == 8));
      else n_pass++;
    end
    n_total++;
    if (mem_moved) $display("FAIL cnt0_memaddr got moved want 0000");
    else n_pass++;
    n_total++;
    if (!done_ok) $display("FAIL cnt0_done got done=%b busy=%b want 1/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    pc_val = 16'h3000;
    for (int k = 0; k < 8; k++) regs[k] = 16'(16'h1110 * k);
    cfg_base = 16'h0010; cfg_count = 16'h0002;
    build_exp(16'h0010, 2);
    start_dump(1'b1);
    collect(0, 0, -1);
    n_total++;
    if (timeout || got_data.size() != 11)
      $display("FAIL basic_len got %0d timeout=%b want 11", got_data.size(), timeout);
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== (i == 10))
        $display("FAIL basic_word%0d got %h/%b/%b want %h/%b/%b", i, got_data[i], got_tag[i],
                 got_last[i], exp_data[i], exp_tag[i], (i == 10));
      else n_pass++;
    end
    n_total++;
    if (!done_ok || busy_err != 0 || early_done != 0)
      $display("FAIL basic_done got ok=%b busy_err=%0d early_done=%0d want 1/0/0",
               done_ok, busy_err, early_done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    pc_val = 16'hBEEF;
    for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
    cfg_base = 16'h2000; cfg_count = 16'h0003;
    build_exp(16'h2000, 3);
    start_dump(1'b1);
    collect(2, 0, -1);
    n_total++;
    if (stall_cnt != 5 || stall_viol != 0)
      $display("FAIL bp_stall got stalls=%0d changes=%0d want 5/0", stall_cnt, stall_viol);
    else n_pass++;
    n_total++;
    if (timeout || got_data.size() != exp_data.size())
      $display("FAIL bp_len got %0d want %0d", got_data.size(), exp_data.size());
    else n_pass++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i])
        $display("FAIL bp_word%0d got %h/%b want %h/%b", i, got_data[i], got_tag[i],
                 exp_data[i], exp_tag[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap;
    cfg_base = 16'hFFFE; cfg_count = 16'h0004;
    build_exp(16'hFFFE, 4);
    start_dump(1'b1);
    collect(0, 0, -1);
    n_total++;
    if (timeout || got_data.size() != 13)
      $display("FAIL wrap_len got %0d want 13", got_data.size());
    else n_pass++;
    for (int i = 9; i < exp_data.size() && i < got_data.size(); i++) begin
      n_total++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_last[i] !== (i == 12))
        $display("FAIL wrap_word%0d got addr=%h data=%h last=%b want addr=%h data=%h last=%b",
                 i, got_addr[i], got_data[i], got_last[i], exp_addr[i], exp_data[i], (i == 12));
      else n_pass++;
    end
  endtask

  task automatic test_abort;
    cfg_base = 16'h0100; cfg_count = 16'h0006;
    start_dump(1'b1);
    collect(0, 4, -1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'h0000 ||
        rf_debug_addr !== 3'd0 || mem_debug_addr !== 16'h0000)
      $display("FAIL abort_reset got busy=%b done=%b valid=%b data=%h rf=%0d want 0",
               busy, done, out_valid, out_data, rf_debug_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_nodone got done=%b busy=%b want 0/0", done, busy);
    else n_pass++;
    pc_val = 16'h5151;
    cfg_base = 16'h0040; cfg_count = 16'h0001;
    build_exp(16'h0040, 1);
    start_dump(1'b0);
    collect(0, 0, -1);
    n_total++;
    if (timeout || got_data.size() != 10 || got_tag[0] !== 2'b00 || got_data[0] !== 16'h5151)
      $display("FAIL abort_fresh got len=%0d first_tag=%b want 10/00", got_data.size(),
               (got_tag.size() > 0) ? got_tag[0] : 2'bxx);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int t = 0; t < 5; t++) begin
      logic [15:0] base;
      int cnt;
      pc_val = 16'($urandom);
      for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
      base = 16'($urandom);
      cnt = $urandom_range(0, 6);
      cfg_base = base; cfg_count = 16'(cnt);
      build_exp(base, cnt);
      start_dump(1'b1);
      collect(1, 0, 5);
      n_total++;
      if (timeout || got_data.size() != exp_data.size())
        $display("FAIL rand%0d_len got %0d want %0d", t, got_data.size(), exp_data.size());
      else n_pass++;
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
        n_total++;
        if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] ||
            got_last[i] !== (i == exp_data.size() - 1))
          $display("FAIL rand%0d_word%0d got %h/%b/%b want %h/%b/%b", t, i, got_data[i],
                   got_tag[i], got_last[i], exp_data[i], exp_tag[i], (i == exp_data.size() - 1));
        else n_pass++;
      end
      n_total++;
      if (!done_ok) $display("FAIL rand%0d_done got 0 want 1", t);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    cfg_base = 16'h0300; cfg_count = 16'h0001;
    start_dump(1'b1);
    collect(0, 0, -1);
    // Collector returns in the done cycle; start issued now must be accepted.
    pc_val = 16'h7777;
    cfg_base = 16'h0A00; cfg_count = 16'h0002;
    build_exp(16'h0A00, 2);
    start_dump(1'b0);
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy);
    else n_pass++;
    collect(0, 0, -1);
    n_total++;
    if (timeout || got_data.size() != 11 || got_data[0] !== 16'h7777 || got_data[10] !== exp_data[10])
      $display("FAIL b2b_dump got len=%0d want 11", got_data.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b1; cfg_base = 16'h0000; cfg_count = 16'h0000;
    pc_val = 16'h0000;
    for (int k = 0; k < 8; k++) regs[k] = 16'h0000;
    test_reset();
    test_count_zero();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
